// File: rtl/pc_stack.sv
// Fetch-stage program counter: increment, absolute/relative branch, call/return
// through a LIFO return-address stack, and interrupt vector entry with sticky stack errors.
module pc_stack #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(16'hFFF0),
   parameter int STACK_DEPTH = 8,
   parameter int SPW = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             increment,
   input  logic             branch,
   input  logic             bra_rel,
   input  logic [WIDTH-1:0] bra_add,
   input  logic             call,
   input  logic             ret,
   input  logic             irq,
   output logic [WIDTH-1:0] address,
   output logic [SPW-1:0]   depth,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             ovf_err,
   output logic             unf_err
);

   localparam logic [SPW-1:0] DEPTH_MAX = SPW'(STACK_DEPTH);

   // Sized to the full pointer range so depth indexes it directly; entries past
   // STACK_DEPTH-1 are never written.
   logic [WIDTH-1:0] stack_mem [2**SPW];

   logic [WIDTH-1:0] next_address;
   logic [SPW-1:0]   next_depth;
   logic             push;
   logic [WIDTH-1:0] push_dat;
   logic             set_ovf;
   logic             set_unf;

   assign stack_full  = (depth == DEPTH_MAX);
   assign stack_empty = (depth == '0);

   always_comb begin
      next_address = address;
      next_depth   = depth;
      push         = 1'b0;
      push_dat     = address + WIDTH'(1);
      set_ovf      = 1'b0;
      set_unf      = 1'b0;
      if (irq) begin
         if (stack_full) begin
            set_ovf = 1'b1;
         end else begin
            // Interrupted instruction has not executed yet, so it is the return point.
            push         = 1'b1;
            push_dat     = address;
            next_address = IRQ_VECTOR;
            next_depth   = depth + SPW'(1);
         end
      end else if (ret) begin
         if (stack_empty) begin
            set_unf = 1'b1;
         end else begin
            next_address = stack_mem[depth - SPW'(1)];
            next_depth   = depth - SPW'(1);
         end
      end else if (call) begin
         if (stack_full) begin
            set_ovf = 1'b1;
         end else begin
            push         = 1'b1;
            next_address = bra_add;
            next_depth   = depth + SPW'(1);
         end
      end else if (branch) begin
         // Two's-complement offset add is the same modular sum as unsigned.
         next_address = bra_rel ? (address + bra_add) : bra_add;
      end else if (increment) begin
         next_address = address + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         address <= RESET_VECTOR;
         depth   <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         address <= next_address;
         depth   <= next_depth;
         ovf_err <= ovf_err | set_ovf;
         unf_err <= unf_err | set_unf;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[depth] <= push_dat;
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// Directed plan scenarios followed by random requests, checked against a queue-based PC model.
module tb_pc_stack;
   localparam int W   = 16;
   localparam int D   = 2;
   localparam int SPW = $clog2(D + 1);
   localparam logic [W-1:0] RV = 16'h0100;
   localparam logic [W-1:0] IV = 16'hFFF0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic increment = 1'b0, branch = 1'b0, bra_rel = 1'b0, call = 1'b0, ret = 1'b0, irq = 1'b0;
   logic [W-1:0] bra_add = '0;
   logic [W-1:0] address;
   logic [SPW-1:0] depth;
   logic stack_full, stack_empty, ovf_err, unf_err;

   int total = 0;
   int bad = 0;

   logic [W-1:0] m_addr;
   logic [W-1:0] m_stk[$];
   logic m_ovf, m_unf;

   pc_stack #(.WIDTH(W), .RESET_VECTOR(RV), .IRQ_VECTOR(IV), .STACK_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .increment(increment), .branch(branch), .bra_rel(bra_rel),
      .bra_add(bra_add), .call(call), .ret(ret), .irq(irq), .address(address),
      .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One action per cycle in priority order; the stack is a plain queue.
   task automatic model_step();
      if (irq) begin
         if (m_stk.size() == D) m_ovf = 1'b1;
         else begin m_stk.push_back(m_addr); m_addr = IV; end
      end else if (ret) begin
         if (m_stk.size() == 0) m_unf = 1'b1;
         else m_addr = m_stk.pop_back();
      end else if (call) begin
         if (m_stk.size() == D) m_ovf = 1'b1;
         else begin m_stk.push_back(m_addr + 16'd1); m_addr = bra_add; end
      end else if (branch) begin
         if (bra_rel) m_addr = W'(int'(m_addr) + int'($signed(bra_add)));
         else m_addr = bra_add;
      end else if (increment) begin
         m_addr = m_addr + 16'd1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/addr"}, 32'(address), 32'(m_addr));
      chk({tag, "/depth"}, 32'(depth), 32'(m_stk.size()));
      chk({tag, "/full"}, 32'(stack_full), 32'(m_stk.size() == D));
      chk({tag, "/empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
      chk({tag, "/ovf"}, 32'(ovf_err), 32'(m_ovf));
      chk({tag, "/unf"}, 32'(unf_err), 32'(m_unf));
   endtask

   task automatic step(input string tag, input logic inc, input logic br, input logic rel,
                       input logic [W-1:0] badd, input logic cl, input logic rt, input logic iq);
      increment = inc; branch = br; bra_rel = rel; bra_add = badd;
      call = cl; ret = rt; irq = iq;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
      increment = 0; branch = 0; bra_rel = 0; call = 0; ret = 0; irq = 0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_all("reset");
      chk("reset/addr_const", 32'(address), 32'h0100);
      rst = 1'b0;

      step("inc1", 1, 0, 0, '0, 0, 0, 0);
      step("inc2", 1, 0, 0, '0, 0, 0, 0);
      step("inc3", 1, 0, 0, '0, 0, 0, 0);
      chk("inc3/const", 32'(address), 32'h0103);
      // Asynchronous reset mid-cycle, no clock edge in between.
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst/addr", 32'(address), 32'h0100);
      chk("async_rst/depth", 32'(depth), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      step("br_abs10", 0, 1, 0, 16'h0010, 0, 0, 0);
      step("br_rel", 0, 1, 1, 16'hFFFC, 0, 0, 0);
      chk("br_rel/const", 32'(address), 32'h000C);
      step("br_ffff", 0, 1, 0, 16'hFFFF, 0, 0, 0);
      step("inc_wrap", 1, 0, 0, '0, 0, 0, 0);
      chk("inc_wrap/const", 32'(address), 32'h0000);

      step("br_200", 0, 1, 0, 16'h0200, 0, 0, 0);
      step("call300", 0, 0, 0, 16'h0300, 1, 0, 0);
      step("call400", 0, 0, 0, 16'h0400, 1, 0, 0);
      step("ret1", 0, 0, 0, '0, 0, 1, 0);
      chk("ret1/const", 32'(address), 32'h0301);
      step("ret2", 0, 0, 0, '0, 0, 1, 0);
      chk("ret2/const", 32'(address), 32'h0201);
      chk("ret2/empty", 32'(stack_empty), 32'h1);

      do_reset("rst_b");
      step("c700", 0, 0, 0, 16'h0700, 1, 0, 0);
      step("c800", 0, 0, 0, 16'h0800, 1, 0, 0);
      step("c500_ovf", 0, 0, 0, 16'h0500, 1, 0, 0);
      chk("ovf/addr", 32'(address), 32'h0800);
      chk("ovf/flag", 32'(ovf_err), 32'h1);
      step("r1", 0, 0, 0, '0, 0, 1, 0);
      step("r2", 0, 0, 0, '0, 0, 1, 0);
      step("r3_unf", 0, 0, 0, '0, 0, 1, 0);
      chk("unf/addr", 32'(address), 32'h0101);
      chk("unf/flag", 32'(unf_err), 32'h1);
      step("hold1", 0, 0, 0, 16'h1234, 0, 0, 0);
      step("inc_sticky", 1, 0, 0, '0, 0, 0, 0);
      chk("sticky/ovf", 32'(ovf_err), 32'h1);
      do_reset("rst_c");

      step("br_42", 0, 1, 0, 16'h0042, 0, 0, 0);
      step("irq_prio", 1, 0, 0, '0, 0, 1, 1);
      chk("irq/addr", 32'(address), 32'hFFF0);
      chk("irq/depth", 32'(depth), 32'h1);
      step("irq_ret", 0, 0, 0, '0, 0, 1, 0);
      chk("irq_ret/addr", 32'(address), 32'h0042);
      step("call_vs_br", 0, 1, 0, 16'h0600, 1, 0, 0);
      chk("call_vs_br/addr", 32'(address), 32'h0600);
      step("ret_43", 0, 0, 0, '0, 0, 1, 0);
      chk("ret_43/addr", 32'(address), 32'h0043);

      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 149) do_reset("rnd_rst");
         step("rnd",
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)),
              W'($urandom),
              1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 7) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the MOSby core; successor to the 16-bit increment/branch PC.
- Adds relative branches, a hardware return-address stack for call/return, and an interrupt vector entry.
- Sits in the fetch stage; `address` drives instruction-memory addressing.

Parameters:
- WIDTH, 16, address/PC width in bits.
- RESET_VECTOR, 0, address loaded on reset.
- IRQ_VECTOR, 16'hFFF0, interrupt entry address (truncated to WIDTH).
- STACK_DEPTH, 8, number of return-stack entries (>=1).
- SPW, $clog2(STACK_DEPTH+1), stack-pointer width (derived; not overridden).

Ports:
- clk  in  1  clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- increment  in  1  advance PC by 1.
- branch  in  1  load branch target.
- bra_rel  in  1  when branch=1: 0 = absolute target, 1 = PC-relative.
- bra_add  in  WIDTH  branch/call target, or two's-complement offset when bra_rel=1.
- call  in  1  push return address, jump to bra_add (always absolute).
- ret  in  1  pop return address into PC.
- irq  in  1  interrupt request, sampled each cycle.
- address  out  WIDTH  current PC (registered).
- depth  out  SPW  current stack occupancy.
- stack_full  out  1  depth == STACK_DEPTH (combinational from depth).
- stack_empty  out  1  depth == 0 (combinational from depth).
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async assert, any time): address=RESET_VECTOR; depth=0; ovf_err=0; unf_err=0. Stack contents are don't-care.
- Reset mid-operation discards all stacked addresses. The first update occurs on the first rising edge after rst deasserts.
- All updates occur on the rising edge of clk. address reflects the new value after that edge (1-cycle latency, no combinational path to address).
- Exactly one action per cycle, by fixed priority: irq > ret > call > branch > increment > hold.
- irq:
  - If not full: push current address (the interrupted instruction is re-executed on return), address=IRQ_VECTOR, depth+1.
  - If full: ovf_err=1, address and depth unchanged.
- ret:
  - If not empty: address=top entry, depth-1.
  - If empty: unf_err=1, address unchanged.
- call:
  - If not full: push address+1 (mod 2^WIDTH), address=bra_add, depth+1.
  - If full: ovf_err=1, address and depth unchanged (call not taken).
- branch:
  - bra_rel=0: address=bra_add.
  - bra_rel=1: address=address+bra_add, where bra_add is interpreted as signed WIDTH-bit; result mod 2^WIDTH (wraps both directions).
- increment: address=address+1 mod 2^WIDTH; all-ones wraps to 0.
- hold (no request active): all state unchanged.
- Stack is LIFO, indexed by depth. A push writes entry[depth]; a pop reads entry[depth-1].
- Lower-priority requests in the same cycle are dropped, not queued. Example: irq and ret together → irq is taken, ret is lost.
- ovf_err and unf_err clear only on rst. Error cycles do not alter any other state.
- Inputs are X-free after reset deassertion. No X propagation is required when all requests are low.

Test Plan:
- Reset/increment: WIDTH=16, RESET_VECTOR=16'h0100, rst pulse then increment=1 for 3 cycles → address 0100,0101,0102,0103; depth=0. Assert rst asynchronously mid-clock → address=0100 immediately, without a clock edge.
- Branches and wrap:
  - address=16'h0010, branch=1, bra_rel=1, bra_add=16'hFFFC → 000C.
  - Then bra_rel=0, bra_add=16'hFFFF → FFFF.
  - Then increment → 0000.
- Call/return nesting: from 0200, call bra_add=0300 → address=0300, depth=1; call bra_add=0400 → 0400, depth=2; ret → 0301, depth=1; ret → 0201, depth=0, stack_empty=1.
- Overflow/underflow, STACK_DEPTH=2:
  - Two calls, then a third call with bra_add=0500 → address unchanged, depth=2, stack_full=1, ovf_err=1.
  - Three rets → the third leaves address unchanged and sets unf_err=1.
  - Both flags stay 1 until rst.
- Interrupt and priority:
  - address=0042, irq=1, ret=1, increment=1 in the same cycle → address=IRQ_VECTOR (FFF0), depth=1.
  - Next cycle ret → 0042.
  - Same cycle: call=1, branch=1, bra_add=0600 → call taken; push 0043, address=0600.
